gmii_rx_checker: RTL and testbench
==================================

GMII_RX_CHECKER -- requirements
Module: gmii_rx_checker

Interface
REQ-001 SHALL have parameter MIN_FRAME_LEN, default 64, minimum legal frame length in bytes, destination MAC through FCS inclusive.
REQ-002 SHALL have parameter MAX_FRAME_LEN, default 1518, maximum legal frame length in bytes, same counting.
REQ-003 SHALL have port clk125  in  1  sole clock, 125 MHz; all logic on its rising edge.
REQ-004 SHALL have port rst_125_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port gmii_rxd  in  8  receive byte from the transceiver.
REQ-006 SHALL have port gmii_rx_dv  in  1  receive data valid.
REQ-007 SHALL have port gmii_rx_er  in  1  receive error.
REQ-008 SHALL have port rxd_o  out  8  registered copy of gmii_rxd, toward the UDP stack.
REQ-009 SHALL have port rx_dv_o  out  1  registered copy of gmii_rx_dv.
REQ-010 SHALL have port frame_good  out  1  one-cycle pulse: frame passed all checks.
REQ-011 SHALL have port frame_bad  out  1  one-cycle pulse: frame failed at least one check.
REQ-012 SHALL have port good_cnt  out  32  good-frame count, saturating.
REQ-013 SHALL have port crc_err_cnt, runt_cnt, giant_cnt, align_err_cnt, rx_er_cnt  out  16 each  per-cause error counts, saturating.

Function
REQ-014 SHALL forward gmii_rxd and gmii_rx_dv to rxd_o and rx_dv_o with exactly 1 cycle latency, unmodified, regardless of check results.
REQ-015 SHALL implement states IDLE, PREAMBLE, DATA and DROP.
REQ-016 IDLE: on dv=1 and byte 0x55, go to PREAMBLE; on dv=1 and any other byte (SFD included), go to DROP and flag alignment error.
REQ-017 PREAMBLE: on 0x55, stay; on 0xD5, go to DATA with byte count 0 and CRC seeded 0xFFFFFFFF; on any other byte, or dv falling, go to DROP or IDLE respectively and flag alignment error.
REQ-018 DATA: each dv=1 byte SHALL update the byte count (11-bit, saturating at 2047) and the CRC-32 (poly 0x04C11DB7, reflected, LSB-first).
REQ-019 DROP: SHALL ignore bytes until dv=0, then return to IDLE.
REQ-020 End of frame SHALL be the first cycle dv=0 is sampled in DATA; the state then returns to IDLE.
REQ-021 Checks at end of frame: CRC residue must equal 0xC704DD7B, else crc error; count < MIN_FRAME_LEN gives runt; count > MAX_FRAME_LEN gives giant; rx_er seen any cycle since SFD gives rx_er error.
REQ-022 Exactly one of frame_good or frame_bad SHALL pulse high, for 1 cycle, in the cycle after end of frame.
REQ-023 The cycle after a DROP-to-IDLE or PREAMBLE-to-IDLE alignment exit SHALL pulse frame_bad and increment align_err_cnt.
REQ-024 Multiple causes in one frame SHALL each increment their own counter; frame_bad still pulses once.
REQ-025 Counters SHALL update in the same cycle as the pulse and hold at all-ones rather than wrap.
REQ-026 A new frame whose dv rises in the cycle after end of frame SHALL be processed normally; IFG of 0 SHALL be tolerated.
REQ-027 gmii_rx_er with dv=0 (carrier extension) SHALL be ignored.

Reset
REQ-028 While rst_125_n=0 at a clock edge: state IDLE; rxd_o=0x00; rx_dv_o, frame_good, frame_bad =0; all counters 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, bytes SHALL be ignored until dv is first sampled 0.

Verification
REQ-030 7x0x55, 0xD5, 60 payload bytes plus correct 4-byte FCS (64 total) -> frame_good 1 cycle after dv falls, good_cnt=1, rx_dv_o and rxd_o follow the input 1 cycle late.
REQ-031 Same frame with one payload bit flipped -> frame_bad, crc_err_cnt=1, good_cnt=0.
REQ-032 60-byte frame with valid FCS -> frame_bad, runt_cnt=1; 1519-byte valid frame -> frame_bad, giant_cnt=1.
REQ-033 Valid 64-byte frame with rx_er=1 for 1 cycle mid-data -> frame_bad, rx_er_cnt=1, crc_err_cnt unchanged.
REQ-034 Frame starting 0x55,0x12 -> align_err_cnt=1, no further pulse for that frame; back-to-back valid frames with IFG 0 -> good_cnt=2.
REQ-035 rst_125_n low for 1 cycle at data byte 30 -> no pulse, counters 0; next valid frame -> good_cnt=1.

Source files
------------

// File: rtl/gmii_rx_checker.sv
// GMII receive checker: forwards the byte stream one cycle late and classifies
// each frame by preamble alignment, FCS, length and rx_er, keeping per-cause counts.
module gmii_rx_checker #(
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic        clk125,
    input  logic        rst_125_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rxd_o,
    output logic        rx_dv_o,
    output logic        frame_good,
    output logic        frame_bad,
    output logic [31:0] good_cnt,
    output logic [15:0] crc_err_cnt,
    output logic [15:0] runt_cnt,
    output logic [15:0] giant_cnt,
    output logic [15:0] align_err_cnt,
    output logic [15:0] rx_er_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_rxd;
    logic        r_rx_dv;
    logic        r_good;
    logic        r_bad;
    logic [31:0] r_good_cnt;
    logic [15:0] r_crc_err_cnt;
    logic [15:0] r_runt_cnt;
    logic [15:0] r_giant_cnt;
    logic [15:0] r_align_err_cnt;
    logic [15:0] r_rx_er_cnt;

    logic        r_armed;
    logic [10:0] r_byte_cnt;
    logic [31:0] r_crc;
    logic        r_rx_er_seen;

    logic        w_sfd;
    logic        w_eof;
    logic        w_align_exit;
    logic [31:0] w_residue;
    logic        w_crc_err;
    logic        w_runt;
    logic        w_giant;
    logic        w_frame_ok;
    logic [31:0] w_crc_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
            else      c = c >> 1;
        end
        return c;
    endfunction

    assign w_crc_next = crc_byte(r_crc, gmii_rxd);

    always_ff @(posedge clk125) begin
        if (!rst_125_n) r_state <= IDLE;
        else            r_state <= w_next_state;
    end

    // r_armed holds off frame detection after reset until the line has gone idle once
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (gmii_rx_dv && r_armed) begin
                    if (gmii_rxd == 8'h55) w_next_state = PREAMBLE;
                    else                   w_next_state = DROP;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv)             w_next_state = IDLE;
                else if (gmii_rxd == 8'hD5)  w_next_state = DATA;
                else if (gmii_rxd != 8'h55)  w_next_state = DROP;
            end
            DATA: if (!gmii_rx_dv) w_next_state = IDLE;
            DROP: if (!gmii_rx_dv) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The reflected register holds the residue bit-reversed relative to 0xC704DD7B
    always_comb begin
        w_sfd        = (r_state == PREAMBLE) && gmii_rx_dv && (gmii_rxd == 8'hD5);
        w_eof        = (r_state == DATA) && !gmii_rx_dv;
        w_align_exit = ((r_state == PREAMBLE) || (r_state == DROP)) && !gmii_rx_dv;
        w_residue    = '0;
        for (int i = 0; i < 32; i++) w_residue[i] = r_crc[31-i];
        w_crc_err    = (w_residue != 32'hC704DD7B);
        w_runt       = (32'(r_byte_cnt) < MIN_FRAME_LEN);
        w_giant      = (32'(r_byte_cnt) > MAX_FRAME_LEN);
        w_frame_ok   = !(w_crc_err || w_runt || w_giant || r_rx_er_seen);
    end

    always_ff @(posedge clk125) begin
        if (!rst_125_n) begin
            r_armed      <= 1'b0;
            r_byte_cnt   <= '0;
            r_crc        <= 32'hFFFFFFFF;
            r_rx_er_seen <= 1'b0;
        end else begin
            if (!gmii_rx_dv) r_armed <= 1'b1;
            if (w_sfd) begin
                r_byte_cnt   <= '0;
                r_crc        <= 32'hFFFFFFFF;
                r_rx_er_seen <= gmii_rx_er;
            end else if ((r_state == DATA) && gmii_rx_dv) begin
                if (r_byte_cnt != 11'h7FF) r_byte_cnt <= r_byte_cnt + 11'd1;
                r_crc <= w_crc_next;
                if (gmii_rx_er) r_rx_er_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk125) begin
        if (!rst_125_n) begin
            r_rxd           <= 8'h00;
            r_rx_dv         <= 1'b0;
            r_good          <= 1'b0;
            r_bad           <= 1'b0;
            r_good_cnt      <= '0;
            r_crc_err_cnt   <= '0;
            r_runt_cnt      <= '0;
            r_giant_cnt     <= '0;
            r_align_err_cnt <= '0;
            r_rx_er_cnt     <= '0;
        end else begin
            r_rxd   <= gmii_rxd;
            r_rx_dv <= gmii_rx_dv;
            r_good  <= 1'b0;
            r_bad   <= 1'b0;
            if (w_eof) begin
                if (w_frame_ok) begin
                    r_good <= 1'b1;
                    if (r_good_cnt != 32'hFFFFFFFF) r_good_cnt <= r_good_cnt + 32'd1;
                end else begin
                    r_bad <= 1'b1;
                end
                if (w_crc_err && (r_crc_err_cnt != 16'hFFFF)) r_crc_err_cnt <= r_crc_err_cnt + 16'd1;
                if (w_runt && (r_runt_cnt != 16'hFFFF))       r_runt_cnt    <= r_runt_cnt + 16'd1;
                if (w_giant && (r_giant_cnt != 16'hFFFF))     r_giant_cnt   <= r_giant_cnt + 16'd1;
                if (r_rx_er_seen && (r_rx_er_cnt != 16'hFFFF)) r_rx_er_cnt  <= r_rx_er_cnt + 16'd1;
            end
            if (w_align_exit) begin
                r_bad <= 1'b1;
                if (r_align_err_cnt != 16'hFFFF) r_align_err_cnt <= r_align_err_cnt + 16'd1;
            end
        end
    end

    assign rxd_o         = r_rxd;
    assign rx_dv_o       = r_rx_dv;
    assign frame_good    = r_good;
    assign frame_bad     = r_bad;
    assign good_cnt      = r_good_cnt;
    assign crc_err_cnt   = r_crc_err_cnt;
    assign runt_cnt      = r_runt_cnt;
    assign giant_cnt     = r_giant_cnt;
    assign align_err_cnt = r_align_err_cnt;
    assign rx_er_cnt     = r_rx_er_cnt;

endmodule

// File: tb/tb_gmii_rx_checker.sv
// Bench for gmii_rx_checker: directed and random frames judged by a frame-level
// model (FCS recomputed over the payload, length and rx_er rules), checked every cycle.
module tb_gmii_rx_checker;

    logic        clk125 = 1'b0;
    logic        rst_125_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  rxd_o;
    logic        rx_dv_o;
    logic        frame_good;
    logic        frame_bad;
    logic [31:0] good_cnt;
    logic [15:0] crc_err_cnt;
    logic [15:0] runt_cnt;
    logic [15:0] giant_cnt;
    logic [15:0] align_err_cnt;
    logic [15:0] rx_er_cnt;

    gmii_rx_checker #(
        .MIN_FRAME_LEN(64),
        .MAX_FRAME_LEN(1518)
    ) dut (
        .clk125       (clk125),
        .rst_125_n    (rst_125_n),
        .gmii_rxd     (gmii_rxd),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .rxd_o        (rxd_o),
        .rx_dv_o      (rx_dv_o),
        .frame_good   (frame_good),
        .frame_bad    (frame_bad),
        .good_cnt     (good_cnt),
        .crc_err_cnt  (crc_err_cnt),
        .runt_cnt     (runt_cnt),
        .giant_cnt    (giant_cnt),
        .align_err_cnt(align_err_cnt),
        .rx_er_cnt    (rx_er_cnt)
    );

    always #4 clk125 = ~clk125;

    int          passed = 0;
    int          failed = 0;
    int          checks = 0;
    logic [7:0]  frame[$];
    logic        expDv = 1'b0;
    logic [7:0]  expD = 8'h00;
    logic        expGood = 1'b0;
    logic        expBad = 1'b0;
    int unsigned mGood = 0;
    int          mCrc = 0, mRunt = 0, mGiant = 0, mAlign = 0, mRxEr = 0;

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic logic [31:0] fcsOf(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h000000, frame[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks what the previous edge produced, then drives the next cycle's inputs
    task automatic applyStimulus(input logic rstN, input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk125);
        checkOutput("rx_dv_o", {31'b0, rx_dv_o}, {31'b0, expDv});
        checkOutput("rxd_o", {24'b0, rxd_o}, {24'b0, expD});
        checkOutput("frame_good", {31'b0, frame_good}, {31'b0, expGood});
        checkOutput("frame_bad", {31'b0, frame_bad}, {31'b0, expBad});
        checkOutput("good_cnt", good_cnt, mGood);
        checkOutput("crc_err_cnt", {16'b0, crc_err_cnt}, mCrc);
        checkOutput("runt_cnt", {16'b0, runt_cnt}, mRunt);
        checkOutput("giant_cnt", {16'b0, giant_cnt}, mGiant);
        checkOutput("align_err_cnt", {16'b0, align_err_cnt}, mAlign);
        checkOutput("rx_er_cnt", {16'b0, rx_er_cnt}, mRxEr);
        expGood = 1'b0;
        expBad  = 1'b0;
        if (!rstN) begin
            mGood = 0; mCrc = 0; mRunt = 0; mGiant = 0; mAlign = 0; mRxEr = 0;
        end
        expDv = rstN ? dv : 1'b0;
        expD  = rstN ? d : 8'h00;
        rst_125_n  = rstN;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
    endtask

    task automatic buildFrame(input int len, input int flipBit);
        logic [31:0] c;
        logic [7:0]  t;
        frame.delete();
        for (int i = 0; i < len - 4; i++) frame.push_back(8'($urandom));
        c = fcsOf(len - 4);
        frame.push_back(c[7:0]);
        frame.push_back(c[15:8]);
        frame.push_back(c[23:16]);
        frame.push_back(c[31:24]);
        if (flipBit >= 0) begin
            t = frame[flipBit / 8];
            t[flipBit % 8] = ~t[flipBit % 8];
            frame[flipBit / 8] = t;
        end
    endtask

    task automatic sendFrame(input int erIdx, input int rstIdx);
        int          len;
        logic [31:0] fcsField;
        logic        crcBad, runt, giant, rxEr;
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frame.size(); i++)
            applyStimulus(i != rstIdx, 1'b1, i == erIdx, frame[i]);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        if (rstIdx < 0) begin
            len      = frame.size();
            fcsField = {frame[len-1], frame[len-2], frame[len-3], frame[len-4]};
            crcBad   = (fcsOf(len - 4) != fcsField);
            runt     = (len < 64);
            giant    = (len > 1518);
            rxEr     = (erIdx >= 0);
            if (!(crcBad || runt || giant || rxEr)) begin
                expGood = 1'b1;
                if (mGood != 32'hFFFFFFFF) mGood++;
            end else begin
                expBad = 1'b1;
            end
            if (crcBad) mCrc   = sat16(mCrc);
            if (runt)   mRunt  = sat16(mRunt);
            if (giant)  mGiant = sat16(mGiant);
            if (rxEr)   mRxEr  = sat16(mRxEr);
        end
    endtask

    task automatic alignExit();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        expBad = 1'b1;
        mAlign = sat16(mAlign);
    endtask

    initial begin
        int len, flip, er;
        rst_125_n  = 1'b0;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        idle(4);

        buildFrame(64, -1);        sendFrame(-1, -1); idle(3);
        buildFrame(64, 8 * 20 + 3); sendFrame(-1, -1); idle(3);
        buildFrame(60, -1);        sendFrame(-1, -1); idle(3);
        buildFrame(1519, -1);      sendFrame(-1, -1); idle(3);
        buildFrame(64, -1);        sendFrame(30, -1); idle(3);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h12);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom));
        alignExit(); idle(3);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom));
        alignExit(); idle(2);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        alignExit(); idle(2);

        buildFrame(64, -1); sendFrame(-1, -1);
        buildFrame(70, -1); sendFrame(-1, -1); idle(3);

        buildFrame(64, -1); sendFrame(-1, 30); idle(3);
        buildFrame(64, -1); sendFrame(-1, -1); idle(3);

        for (int n = 0; n < 14; n++) begin
            len  = int'($urandom_range(140, 56));
            flip = -1;
            er   = -1;
            if ($urandom_range(3, 0) == 0) flip = int'($urandom_range(8 * (len - 4) - 1, 0));
            if ($urandom_range(4, 0) == 0) er = int'($urandom_range(len - 1, 0));
            buildFrame(len, flip);
            sendFrame(er, -1);
            idle(int'($urandom_range(3, 0)));
        end
        idle(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
